// File: rtl/int_priority_dispatch.sv
// -----------------------------------------------------------------------------
// int_priority_dispatch
//
// Sits between the interrupt collector (latched pending bits) and the CPU.
// Each service round picks one eligible source: highest programmed priority
// wins, and ties are broken round-robin starting at rr_ptr. The chosen source
// is offered to the CPU over an irq/ack/eoi handshake. Once the CPU signals
// end-of-interrupt, a one-cycle one-hot clear pulse retires the source in the
// collector. Only one interrupt is in flight at any time (no preemption).
//
// Ports
//   clk          in   1                   clock
//   rst_x        in   1                   asynchronous active-low reset
//   int_pending  in   INT_NUM             latched pending bits (level)
//   int_enable   in   INT_NUM             per-source dispatch enable
//   pri_cfg      in   INT_NUM*PRI_WIDTH   priority of source i at [i*PRI_WIDTH +: PRI_WIDTH]
//   cpu_ack      in   1                   CPU accepts the presented interrupt
//   cpu_eoi      in   1                   CPU has finished servicing it
//   cpu_irq      out  1                   interrupt request to the CPU
//   irq_id       out  ID_WIDTH            index of the presented / in-service source
//   irq_pri      out  PRI_WIDTH           priority of the presented source
//   int_clr      out  INT_NUM             one-hot, one-cycle clear pulse
//   busy         out  1                   dispatcher is not idle
//   timeout_err  out  1                   one-cycle pulse when the CPU never acked
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module int_priority_dispatch #(
  parameter int INT_NUM   = 6,
  parameter int PRI_WIDTH = 2,
  parameter int ID_WIDTH  = 3,
  parameter int TO_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_x,
  input  logic [INT_NUM-1:0]           int_pending,
  input  logic [INT_NUM-1:0]           int_enable,
  input  logic [INT_NUM*PRI_WIDTH-1:0] pri_cfg,
  input  logic                         cpu_ack,
  input  logic                         cpu_eoi,
  output logic                         cpu_irq,
  output logic [ID_WIDTH-1:0]          irq_id,
  output logic [PRI_WIDTH-1:0]         irq_pri,
  output logic [INT_NUM-1:0]           int_clr,
  output logic                         busy,
  output logic                         timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_REQ     = 3'd2,
    ST_SERVICE = 3'd3,
    ST_CLR     = 3'd4
  } state_t;

  // Next source index after v, wrapping INT_NUM-1 back to 0.
  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] v);
    logic [ID_WIDTH-1:0] r;
    if (v == ID_WIDTH'(INT_NUM - 1)) begin
      r = '0;
    end else begin
      r = v + ID_WIDTH'(1);
    end
    return r;
  endfunction

  // Registered state and outputs
  state_t                 state_q,       state_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q,      rr_ptr_d;
  logic [TO_WIDTH-1:0]    to_cnt_q,      to_cnt_d;
  logic                   cpu_irq_q,     cpu_irq_d;
  logic [ID_WIDTH-1:0]    irq_id_q,      irq_id_d;
  logic [PRI_WIDTH-1:0]   irq_pri_q,     irq_pri_d;
  logic [INT_NUM-1:0]     int_clr_q,     int_clr_d;
  logic                   busy_q,        busy_d;
  logic                   timeout_err_q, timeout_err_d;

  // Combinational helpers
  logic [INT_NUM-1:0]     eligible_s;
  logic [PRI_WIDTH-1:0]   pri_s [INT_NUM];
  logic                   win_found_s;
  logic [ID_WIDTH-1:0]    win_id_s;
  logic [PRI_WIDTH-1:0]   win_pri_s;
  logic                   cur_live_s;

  assign eligible_s = int_pending & int_enable;

  // The presented source is still wanted only while it is both pending and enabled.
  assign cur_live_s = int_pending[irq_id_q] & int_enable[irq_id_q];

  // Split the flat priority bus into one field per source.
  for (genvar g = 0; g < INT_NUM; g++) begin : g_pri
    assign pri_s[g] = pri_cfg[g*PRI_WIDTH +: PRI_WIDTH];
  end

  // Arbiter: walk all sources starting at rr_ptr with wrap. A later candidate
  // replaces the current best only on a strictly higher priority, so among
  // equals the first one reached from rr_ptr keeps the win.
  always_comb begin
    logic [ID_WIDTH-1:0] scan_v;
    logic                take_v;
    win_found_s = 1'b0;
    win_id_s    = '0;
    win_pri_s   = '0;
    scan_v      = rr_ptr_q;
    take_v      = 1'b0;
    for (int k = 0; k < INT_NUM; k++) begin
      take_v      = eligible_s[scan_v] & (~win_found_s | (pri_s[scan_v] > win_pri_s));
      win_found_s = win_found_s | take_v;
      win_id_s    = take_v ? scan_v        : win_id_s;
      win_pri_s   = take_v ? pri_s[scan_v] : win_pri_s;
      scan_v      = wrap_inc(scan_v);
    end
  end

  // Next-state and next-output logic for the service round.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    to_cnt_d      = to_cnt_q;
    irq_id_d      = irq_id_q;
    irq_pri_d     = irq_pri_q;
    int_clr_d     = '0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|eligible_s) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARB: begin
        to_cnt_d = '0;
        if (win_found_s) begin
          state_d   = ST_REQ;
          irq_id_d  = win_id_s;
          irq_pri_d = win_pri_s;
        end else begin
          // Everything was withdrawn between IDLE and ARB.
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Ack has precedence over both withdrawal and timeout.
        if (cpu_ack) begin
          state_d = ST_SERVICE;
        end else if (!cur_live_s) begin
          state_d = ST_IDLE;
        end else if (&to_cnt_q) begin
          // Skip past the unacknowledged source so a stuck CPU path
          // cannot starve its equal-priority neighbours forever.
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
          rr_ptr_d      = wrap_inc(irq_id_q);
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end

      ST_SERVICE: begin
        if (cpu_eoi) begin
          state_d = ST_CLR;
        end else begin
          state_d = ST_SERVICE;
        end
      end

      ST_CLR: begin
        int_clr_d[irq_id_q] = 1'b1;
        rr_ptr_d            = wrap_inc(irq_id_q);
        state_d             = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_irq_d = (state_d == ST_REQ);
    busy_d    = (state_d != ST_IDLE);
  end

  // State, pointers and output registers.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      to_cnt_q      <= '0;
      cpu_irq_q     <= 1'b0;
      irq_id_q      <= '0;
      irq_pri_q     <= '0;
      int_clr_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      to_cnt_q      <= to_cnt_d;
      cpu_irq_q     <= cpu_irq_d;
      irq_id_q      <= irq_id_d;
      irq_pri_q     <= irq_pri_d;
      int_clr_q     <= int_clr_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cpu_irq     = cpu_irq_q;
  assign irq_id      = irq_id_q;
  assign irq_pri     = irq_pri_q;
  assign int_clr     = int_clr_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_int_priority_dispatch.sv
// -----------------------------------------------------------------------------
// Testbench for int_priority_dispatch (INT_NUM=6, PRI_WIDTH=2, ID_WIDTH=3,
// TO_WIDTH=4). A round-level reference model predicts every output on every
// cycle; directed scenarios add hand-computed expectations on top. The bench
// also plays the collector: a clear pulse drops the pending bit one edge later.
// -----------------------------------------------------------------------------
module tb_int_priority_dispatch;

  localparam int N  = 6;
  localparam int PW = 2;
  localparam int IW = 3;
  localparam int TW = 4;

  logic            clk         = 1'b0;
  logic            rst_x       = 1'b0;
  logic [N-1:0]    int_pending = '0;
  logic [N-1:0]    int_enable  = '1;
  logic [N*PW-1:0] pri_cfg     = '0;
  logic            cpu_ack     = 1'b0;
  logic            cpu_eoi     = 1'b0;
  logic            cpu_irq;
  logic [IW-1:0]   irq_id;
  logic [PW-1:0]   irq_pri;
  logic [N-1:0]    int_clr;
  logic            busy;
  logic            timeout_err;

  int total = 0;
  int bad   = 0;
  logic [N-1:0] clr_prev = '0;

  int_priority_dispatch #(
    .INT_NUM(N), .PRI_WIDTH(PW), .ID_WIDTH(IW), .TO_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_x(rst_x), .int_pending(int_pending), .int_enable(int_enable),
    .pri_cfg(pri_cfg), .cpu_ack(cpu_ack), .cpu_eoi(cpu_eoi), .cpu_irq(cpu_irq),
    .irq_id(irq_id), .irq_pri(irq_pri), .int_clr(int_clr), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_ARB = 1, P_REQ = 2, P_SVC = 3, P_CLR = 4;
  int           m_phase = P_IDLE;
  int           m_rr    = 0;
  int           m_id    = 0;
  int           m_pri   = 0;
  int           m_waited = 0;   // REQ cycles already spent without ack
  logic         m_irq   = 1'b0;
  logic         m_busy  = 1'b0;
  logic         m_terr  = 1'b0;
  logic [N-1:0] m_clr   = '0;

  function automatic int pri_of(input int i);
    logic [N*PW-1:0] t;
    t = pri_cfg >> (i * PW);
    return int'(t[PW-1:0]);
  endfunction

  initial begin
    logic [N-1:0] elig;
    int best, bp, bd, p, d;
    forever begin
      @(posedge clk or negedge rst_x);
      if (!rst_x) begin
        m_phase = P_IDLE; m_rr = 0; m_id = 0; m_pri = 0; m_waited = 0;
        m_terr = 1'b0; m_clr = '0;
      end else begin
        elig   = int_pending & int_enable;
        m_terr = 1'b0;
        m_clr  = '0;
        if (m_phase == P_IDLE) begin
          if (elig != '0) m_phase = P_ARB;
        end else if (m_phase == P_ARB) begin
          // max priority, then smallest forward distance from rr pointer
          best = -1; bp = -1; bd = N;
          for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
              p = pri_of(i);
              d = (i - m_rr + N) % N;
              if (best < 0 || p > bp || (p == bp && d < bd)) begin
                best = i; bp = p; bd = d;
              end
            end
          end
          if (best >= 0) begin
            m_id = best; m_pri = bp; m_waited = 0; m_phase = P_REQ;
          end else begin
            m_phase = P_IDLE;
          end
        end else if (m_phase == P_REQ) begin
          if (cpu_ack) m_phase = P_SVC;
          else if (!(int_pending[m_id] && int_enable[m_id])) m_phase = P_IDLE;
          else if (m_waited == (1 << TW) - 1) begin
            m_terr = 1'b1; m_rr = (m_id + 1) % N; m_phase = P_IDLE;
          end else m_waited++;
        end else if (m_phase == P_SVC) begin
          if (cpu_eoi) m_phase = P_CLR;
        end else begin
          m_clr = N'(1) << m_id;
          m_rr  = (m_id + 1) % N;
          m_phase = P_IDLE;
        end
      end
      m_irq  = (m_phase == P_REQ);
      m_busy = (m_phase != P_IDLE);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    total++;
    if ({cpu_irq, irq_id, irq_pri, int_clr, busy, timeout_err} !==
        {m_irq, IW'(m_id), PW'(m_pri), m_clr, m_busy, m_terr}) begin
      bad++;
      $display("FAIL model t=%0t got irq=%b id=%0d pri=%0d clr=%b busy=%b terr=%b exp irq=%b id=%0d pri=%0d clr=%b busy=%b terr=%b",
               $time, cpu_irq, irq_id, irq_pri, int_clr, busy, timeout_err,
               m_irq, m_id, m_pri, m_clr, m_busy, m_terr);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock; the collector applies the clear pulse seen in the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    int_pending = int_pending & ~clr_prev;
    clr_prev    = int_clr;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    ticks(2);
    clr_prev = '0;
    rst_x = 1'b1;
  endtask

  task automatic wait_irq();
    int n;
    n = 0;
    while (!cpu_irq && n < 20) begin
      tick();
      n++;
    end
    chk("irq_wait", int'(cpu_irq), 1);
  endtask

  // Full handshake for whatever is presented next; returns the served id.
  task automatic serve(output int id);
    wait_irq();
    id = int'(irq_id);
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    cpu_eoi = 1'b1; tick(); cpu_eoi = 1'b0;
    tick();
    chk("clr_pulse", int'(int_clr), 1 << id);
    tick();
    chk("clr_len", int'(int_clr), 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int id, n;

    // Reset state
    ticks(2);
    chk("rst_irq", int'(cpu_irq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(irq_id), 0);
    chk("rst_clr", int'(int_clr), 0);
    rst_x = 1'b1;

    // 1: priority winner src2 (pri 3) over src0 (pri 1), then src0
    pri_cfg     = 12'h031;
    int_pending = 6'b000101;
    tick();
    chk("t1_arb_irq", int'(cpu_irq), 0);
    chk("t1_arb_busy", int'(busy), 1);
    tick();
    chk("t1_irq", int'(cpu_irq), 1);
    chk("t1_id", int'(irq_id), 2);
    chk("t1_pri", int'(irq_pri), 3);
    serve(id); chk("t1_srv_a", id, 2);
    serve(id); chk("t1_srv_b", id, 0);
    ticks(3);

    // 2: equal priority round-robin 0,1,5 then wrap back to 0
    do_reset();
    pri_cfg     = '0;
    int_pending = 6'b100011;
    serve(id); chk("t2_r1", id, 0);
    serve(id); chk("t2_r2", id, 1);
    serve(id); chk("t2_r3", id, 5);
    ticks(3);
    int_pending = 6'b100001;
    serve(id); chk("t2_r4", id, 0);
    serve(id); chk("t2_r5", id, 5);
    ticks(3);

    // 3: ack timeout on src3, neighbour src4 goes first afterwards
    do_reset();
    pri_cfg     = 12'h280;
    int_pending = 6'b011000;
    wait_irq();
    chk("t3_id", int'(irq_id), 3);
    n = 0;
    while (cpu_irq && n < 40) begin
      tick();
      n++;
    end
    chk("t3_req_cycles", n, 16);
    chk("t3_terr", int'(timeout_err), 1);
    chk("t3_noclr", int'(int_clr), 0);
    tick();
    chk("t3_terr_len", int'(timeout_err), 0);
    serve(id); chk("t3_next", id, 4);
    serve(id); chk("t3_retry", id, 3);
    ticks(3);

    // 4: withdrawal of src4 while presented
    pri_cfg     = '0;
    int_pending = 6'b010000;
    wait_irq();
    chk("t4_id", int'(irq_id), 4);
    int_pending[4] = 1'b0;
    tick();
    chk("t4_irq", int'(cpu_irq), 0);
    chk("t4_busy", int'(busy), 0);
    chk("t4_clr", int'(int_clr), 0);
    chk("t4_terr", int'(timeout_err), 0);
    ticks(2);

    // 5: reset during SERVICE, then redispatch from rr_ptr=0
    int_pending = 6'b100001;
    wait_irq();
    chk("t5_id", int'(irq_id), 5);
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    chk("t5_svc_busy", int'(busy), 1);
    #2 rst_x = 1'b0;
    #1;
    chk("t5_rst_irq", int'(cpu_irq), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_clr", int'(int_clr), 0);
    chk("t5_rst_id", int'(irq_id), 0);
    tick();
    rst_x = 1'b1;
    serve(id); chk("t5_redisp", id, 0);
    serve(id); chk("t5_then", id, 5);
    ticks(3);

    // 6: ack in the same cycle the timeout would fire; stray eoi/ack in IDLE
    int_pending = 6'b000100;
    wait_irq();
    ticks(15);
    chk("t6_still_irq", int'(cpu_irq), 1);
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    chk("t6_irq", int'(cpu_irq), 0);
    chk("t6_busy", int'(busy), 1);
    chk("t6_terr", int'(timeout_err), 0);
    cpu_eoi = 1'b1; tick(); cpu_eoi = 1'b0;
    tick();
    chk("t6_clr", int'(int_clr), 6'b000100);
    ticks(3);
    cpu_eoi = 1'b1; tick(); cpu_eoi = 1'b0;
    chk("t6_eoi_busy", int'(busy), 0);
    chk("t6_eoi_clr", int'(int_clr), 0);
    cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
    chk("t6_ack_busy", int'(busy), 0);
    chk("t6_ack_irq", int'(cpu_irq), 0);
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
